// File: rtl/oam_dma_ctrl.sv
// Sprite-RAM DMA engine: passes CPU bus traffic through while idle, and after a write
// to the trigger address it stalls the CPU and copies one 256-byte page to the OAM data port.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | CPU owns the bus, combinational pass-through
// S_ALIGN | first stall cycle after the trigger, bus idle
// S_ALIGN2| extra idle cycle when the DMA started on an odd cycle
// S_READ  | read byte {page,count} into the latch
// S_WRITE | write the latch to the OAM data port, advance count
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_TRIG_ADDR = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter bit          ALIGN_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        b_rst,
    input  logic [15:0] cpu_addr_out,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_ren,
    input  logic        cpu_wen,
    output logic [7:0]  cpu_data_in,
    output logic        cpu_rdy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_ren,
    output logic        mem_wen,
    input  logic [7:0]  mem_rdata,
    output logic        dma_busy,
    output logic [7:0]  dma_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ALIGN2,
        S_READ,
        S_WRITE
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] page;
    logic [7:0] count;
    logic [7:0] latch;
    logic       parity;
    logic       trig;

    assign trig      = (state == S_IDLE) && cpu_wen && (cpu_addr_out == DMA_TRIG_ADDR);
    assign dma_count = count;

    always_ff @(posedge clk or negedge b_rst) begin
        if (!b_rst) begin
            state  <= S_IDLE;
            page   <= 8'h00;
            count  <= 8'h00;
            latch  <= 8'h00;
            parity <= 1'b0;
        end else begin
            state  <= state_nxt;
            parity <= ~parity;
            case (state)
                S_IDLE: begin
                    if (trig) begin
                        page  <= cpu_data_out;
                        count <= 8'h00;
                    end
                end
                S_READ:  latch <= mem_rdata;
                S_WRITE: count <= count + 8'h01;
                default: ;
            endcase
        end
    end

    // Outside IDLE the CPU is stalled: its strobes are dropped and it sees zero read data.
    always_comb begin
        state_nxt   = state;
        cpu_rdy     = 1'b0;
        dma_busy    = 1'b1;
        cpu_data_in = 8'h00;
        mem_addr    = {page, count};
        mem_wdata   = latch;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        case (state)
            S_IDLE: begin
                cpu_rdy     = 1'b1;
                dma_busy    = 1'b0;
                cpu_data_in = mem_rdata;
                mem_addr    = cpu_addr_out;
                mem_wdata   = cpu_data_out;
                mem_ren     = cpu_ren;
                mem_wen     = cpu_wen;
                if (trig) begin
                    state_nxt = S_ALIGN;
                end
            end
            S_ALIGN: begin
                state_nxt = (ALIGN_EN && parity) ? S_ALIGN2 : S_READ;
            end
            S_ALIGN2: begin
                state_nxt = S_READ;
            end
            S_READ: begin
                mem_ren   = 1'b1;
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_addr  = OAM_DATA_ADDR;
                mem_wen   = 1'b1;
                state_nxt = (count == 8'hFF) ? S_IDLE : S_READ;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: dut0 with odd-cycle alignment, dut1 without, both on
// the same CPU stimulus; a small memory model supplies read data and expected bytes.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        b_rst = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_ren = 1'b0;
    logic        cpu_wen = 1'b0;

    logic [7:0]  cpu_data_in0, cpu_data_in1;
    logic        cpu_rdy0, cpu_rdy1;
    logic [15:0] mem_addr0, mem_addr1;
    logic [7:0]  mem_wdata0, mem_wdata1;
    logic        mem_ren0, mem_ren1;
    logic        mem_wen0, mem_wen1;
    logic [7:0]  mem_rdata0, mem_rdata1;
    logic        dma_busy0, dma_busy1;
    logic [7:0]  dma_count0, dma_count1;

    logic [7:0]  wram [0:511];
    logic [7:0]  oam  [0:255];
    int          edges;
    int          checks = 0;
    int          failures = 0;
    int          hit;

    always #5 clk = ~clk;

    // RAM $0000-$01FF writable; pages $02/$03 preloaded with index / ~index; ROM above $8000.
    function automatic logic [7:0] mem_val(input logic [15:0] a);
        if (a < 16'h0200)        return wram[a[8:0]];
        if (a[15:8] == 8'h02)    return a[7:0];
        if (a[15:8] == 8'h03)    return ~a[7:0];
        if (a >= 16'hFFFA)       return a[0] ? 8'h80 : 8'h00;
        if (a[15])               return a[7:0] ^ 8'h3C;
        return 8'h00;
    endfunction

    assign mem_rdata0 = mem_val(mem_addr0);
    assign mem_rdata1 = mem_val(mem_addr1);

    always @(posedge clk) begin
        if (mem_wen0 && mem_addr0 < 16'h0200) wram[mem_addr0[8:0]] <= mem_wdata0;
    end

    // Edges since reset release; the DUT's parity in a cycle equals edges[0].
    always @(posedge clk or negedge b_rst) begin
        if (!b_rst) edges <= 0;
        else        edges <= edges + 1;
    end

    oam_dma_ctrl #(.ALIGN_EN(1'b1)) dut0 (
        .clk(clk), .b_rst(b_rst),
        .cpu_addr_out(cpu_addr), .cpu_data_out(cpu_wdata),
        .cpu_ren(cpu_ren), .cpu_wen(cpu_wen),
        .cpu_data_in(cpu_data_in0), .cpu_rdy(cpu_rdy0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_ren(mem_ren0), .mem_wen(mem_wen0), .mem_rdata(mem_rdata0),
        .dma_busy(dma_busy0), .dma_count(dma_count0)
    );

    oam_dma_ctrl #(.ALIGN_EN(1'b0)) dut1 (
        .clk(clk), .b_rst(b_rst),
        .cpu_addr_out(cpu_addr), .cpu_data_out(cpu_wdata),
        .cpu_ren(cpu_ren), .cpu_wen(cpu_wen),
        .cpu_data_in(cpu_data_in1), .cpu_rdy(cpu_rdy1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_ren(mem_ren1), .mem_wen(mem_wen1), .mem_rdata(mem_rdata1),
        .dma_busy(dma_busy1), .dma_count(dma_count1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step one cycle if needed so that the ALIGN cycle after a trigger now has parity 'want'.
    task automatic align_par(input bit want);
        if (edges[0] == want) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Trigger from IDLE and follow the whole transfer; optionally inject illegal CPU strobes.
    task automatic dma_xfer(input logic [7:0] page, input int exp_stall, input bit inject);
        int         stall0 = 0, stall1 = 0, idle0 = 0;
        int         rd_idx = 0, wr_idx = 0, first_rd = -1;
        logic [7:0] exp_byte = 8'h00;
        cpu_addr  = 16'h4014;
        cpu_wdata = page;
        cpu_ren   = 1'b0;
        cpu_wen   = 1'b1;
        #1;
        chk("trig_fwd_addr", mem_addr0, 16'h4014);
        chk("trig_fwd_wen", mem_wen0, 1);
        chk("trig_fwd_data", mem_wdata0, page);
        @(posedge clk);
        #1;
        cpu_wen = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (inject && c == 10) begin
                cpu_addr = 16'h4014; cpu_wdata = 8'h07; cpu_wen = 1'b1;
            end
            if (inject && c == 20) begin
                cpu_wen = 1'b0; cpu_addr = 16'h0000; cpu_ren = 1'b1;
            end
            if (inject && c == 30) cpu_ren = 1'b0;
            #1;
            if (!cpu_rdy1) stall1++;
            if (cpu_rdy0 && cpu_rdy1) break;
            if (!cpu_rdy0) begin
                stall0++;
                chk("busy", dma_busy0, 1);
                chk("cpu_data_in_zero", cpu_data_in0, 0);
                chk("strobe_overlap", mem_ren0 & mem_wen0, 0);
                if (mem_ren0) begin
                    if (first_rd < 0) first_rd = c;
                    chk("rd_addr", mem_addr0, {page, rd_idx[7:0]});
                    chk("rd_count", dma_count0, rd_idx[7:0]);
                    chk("rd_alternate", rd_idx, wr_idx);
                    exp_byte = mem_val({page, rd_idx[7:0]});
                    rd_idx++;
                end else if (mem_wen0) begin
                    chk("wr_addr", mem_addr0, 16'h2004);
                    chk("wr_data", mem_wdata0, exp_byte);
                    chk("wr_count", dma_count0, wr_idx[7:0]);
                    chk("wr_alternate", wr_idx + 1, rd_idx);
                    oam[wr_idx[7:0]] = mem_wdata0;
                    wr_idx++;
                end else begin
                    idle0++;
                end
            end
        end
        chk("stall_cycles", stall0, exp_stall);
        chk("stall_noalign", stall1, 513);
        chk("idle_cycles", idle0, exp_stall - 512);
        chk("first_read_cycle", first_rd, exp_stall - 512);
        chk("read_total", rd_idx, 256);
        chk("write_total", wr_idx, 256);
        chk("end_rdy", cpu_rdy0, 1);
        chk("end_busy", dma_busy0, 0);
        chk("end_count", dma_count0, 0);
        chk("end_passthru", mem_addr0, cpu_addr);
    endtask

    initial begin
        // Reset state with a CPU read held on the bus
        cpu_addr = 16'h8000;
        cpu_ren  = 1'b1;
        #2;
        chk("rst_rdy", cpu_rdy0, 1);
        chk("rst_busy", dma_busy0, 0);
        chk("rst_count", dma_count0, 0);
        chk("rst_mem_addr", mem_addr0, 16'h8000);
        chk("rst_mem_ren", mem_ren0, 1);
        chk("rst_rdata", cpu_data_in0, 8'h3C);
        @(negedge clk);
        @(negedge clk);
        b_rst = 1'b1;
        #1;

        // Pass-through read and write
        chk("pt_rd_addr", mem_addr0, 16'h8000);
        chk("pt_rd_ren", mem_ren0, 1);
        chk("pt_rd_data", cpu_data_in0, 8'h3C);
        chk("pt_rdy1", cpu_rdy1, 1);
        @(negedge clk);
        cpu_ren = 1'b0; cpu_wen = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h5A;
        #1;
        chk("pt_wr_wen", mem_wen0, 1);
        chk("pt_wr_ren", mem_ren0, 0);
        chk("pt_wr_addr", mem_addr0, 16'h0010);
        chk("pt_wr_data", mem_wdata0, 8'h5A);
        chk("pt_wr_busy", dma_busy0, 0);
        @(negedge clk);
        cpu_wen = 1'b0; cpu_ren = 1'b1;
        #1;
        chk("pt_readback", cpu_data_in0, 8'h5A);
        @(negedge clk);
        cpu_ren = 1'b0;
        #1;

        // Page $02, even ALIGN cycle: no extra idle cycle
        align_par(1'b0);
        dma_xfer(8'h02, 513, 1'b0);

        // Page $02, odd ALIGN cycle: dut0 inserts ALIGN2, dut1 does not
        align_par(1'b1);
        dma_xfer(8'h02, 514, 1'b0);

        // Page $FF including the vector bytes
        align_par(1'b0);
        dma_xfer(8'hFF, 513, 1'b0);
        chk("oam_ff00", oam[8'h00], 8'h3C);
        chk("oam_fffa", oam[8'hFA], 8'h00);
        chk("oam_fffb", oam[8'hFB], 8'h80);
        chk("oam_fffc", oam[8'hFC], 8'h00);
        chk("oam_fffd", oam[8'hFD], 8'h80);
        chk("oam_fffe", oam[8'hFE], 8'h00);
        chk("oam_ffff", oam[8'hFF], 8'h80);

        // Illegal CPU strobes during a transfer
        align_par(1'b0);
        dma_xfer(8'h02, 513, 1'b1);

        // Back-to-back trigger in the first IDLE cycle
        dma_xfer(8'h03, edges[0] ? 513 : 514, 1'b0);

        // Reset mid-transfer at count $40 during WRITE
        align_par(1'b0);
        cpu_addr = 16'h4014; cpu_wdata = 8'h02; cpu_wen = 1'b1;
        @(posedge clk);
        #1;
        cpu_wen = 1'b0;
        hit = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            #1;
            if (mem_wen0 && dma_count0 == 8'h40) begin
                hit = 1;
                break;
            end
        end
        chk("rst_mid_reached", hit, 1);
        cpu_addr = 16'h8123; cpu_ren = 1'b1;
        b_rst = 1'b0;
        #1;
        chk("rst_mid_rdy", cpu_rdy0, 1);
        chk("rst_mid_busy", dma_busy0, 0);
        chk("rst_mid_count", dma_count0, 0);
        chk("rst_mid_addr", mem_addr0, 16'h8123);
        chk("rst_mid_ren", mem_ren0, 1);
        chk("rst_mid_wen", mem_wen0, 0);
        chk("rst_mid_rdata", cpu_data_in0, 8'h1F);
        chk("rst_mid_rdy1", cpu_rdy1, 1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_rdy", cpu_rdy0, 1);
        b_rst = 1'b1;
        cpu_ren = 1'b0;
        #1;
        align_par(1'b0);
        dma_xfer(8'h03, 513, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
